// File: rtl/m3_pkg.sv
// Shared types and default constants for the speed-ramp controller.
package m3_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HOLD  = 3'd1,
      S_INC   = 3'd2,
      S_DEC   = 3'd3,
      S_TRACK = 3'd4,
      S_BRAKE = 3'd5
   } state_t;

   localparam int PERIOD_W_DEF   = 32;
   localparam int PERIOD_MAX_DEF = 4000000;
   localparam int PERIOD_MIN_DEF = 40;
   localparam int STEP_SHIFT_DEF = 4;
   localparam int ROUND_MAX_DEF  = 3;
   localparam int TICK_MAX_DEF   = 9998;

endpackage

// File: rtl/m3_speed_ramp_ctrl_if.sv
// Request/status bundle between the motor sequencer and the ramp controller.
interface m3_speed_ramp_ctrl_if #(
   parameter int PERIOD_W = 32
);
   logic                workingI;
   logic                nextRoundI;
   logic                forceStopI;
   logic                speedIncI;
   logic                speedDecI;
   logic                targetModeI;
   logic [PERIOD_W-1:0] targetPeriodI;
   logic [PERIOD_W-1:0] periodO;
   logic                atMinO;
   logic                atMaxO;
   logic [2:0]          stateO;
   logic                stepDoneO;
   logic                tickO;

   modport master (
      output workingI, nextRoundI, forceStopI, speedIncI, speedDecI,
             targetModeI, targetPeriodI,
      input  periodO, atMinO, atMaxO, stateO, stepDoneO, tickO
   );

   modport slave (
      input  workingI, nextRoundI, forceStopI, speedIncI, speedDecI,
             targetModeI, targetPeriodI,
      output periodO, atMinO, atMaxO, stateO, stepDoneO, tickO
   );
endinterface

// File: rtl/m3_tick_div.sv
// Free-running tick divider: one-cycle tick every TICK_MAX+1 clocks while enabled.
module m3_tick_div
   import m3_pkg::*;
#(
   parameter int TICK_MAX = TICK_MAX_DEF
) (
   input  logic clkI,
   input  logic nRstI,
   input  logic en,
   output logic tick
);
   localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam logic [TW-1:0] RLD = TW'(TICK_MAX);

   logic [TW-1:0] cnt;

   // Disable restarts the count so the first tick after enable is a full period away.
   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI)                 cnt <= RLD;
      else if (!en || cnt == '0)  cnt <= RLD;
      else                        cnt <= cnt - TW'(1);
   end

   assign tick = en && (cnt == '0);
endmodule

// File: rtl/m3_speed_ramp_ctrl.sv
// Commutation-period ramp controller: per-round stepping toward faster/slower
// period, target tracking and braking, plus a housekeeping tick.
module m3_speed_ramp_ctrl
   import m3_pkg::*;
#(
   parameter int PERIOD_W   = PERIOD_W_DEF,
   parameter int PERIOD_MAX = PERIOD_MAX_DEF,
   parameter int PERIOD_MIN = PERIOD_MIN_DEF,
   parameter int STEP_SHIFT = STEP_SHIFT_DEF,
   parameter int ROUND_MAX  = ROUND_MAX_DEF,
   parameter int TICK_MAX   = TICK_MAX_DEF
) (
   input logic clkI,
   input logic nRstI,
   m3_speed_ramp_ctrl_if.slave bus
);
   localparam int XW = PERIOD_W + 1;
   localparam int RW = (ROUND_MAX > 0) ? $clog2(ROUND_MAX + 1) : 1;
   localparam logic [XW-1:0]       PMAX_X  = XW'(PERIOD_MAX);
   localparam logic [XW-1:0]       PMIN_X  = XW'(PERIOD_MIN);
   localparam logic [PERIOD_W-1:0] PMAX_W  = PMAX_X[PERIOD_W-1:0];
   localparam logic [PERIOD_W-1:0] PMIN_W  = PMIN_X[PERIOD_W-1:0];
   localparam logic [RW-1:0]       RND_RLD = RW'(ROUND_MAX);

   state_t              st, req;
   logic [PERIOD_W-1:0] period;
   logic [RW-1:0]       rnd;
   logic                step_done;

   // One extra bit of headroom so period+step never wraps.
   logic [XW-1:0] p_x, step, dn, up, dn_cl, up_cl, tgt, trk, nxt_p;

   always_comb begin
      p_x  = {1'b0, period};
      step = p_x >> STEP_SHIFT;
      if (step == '0) step = XW'(1);
      dn    = p_x - step;
      up    = p_x + step;
      dn_cl = (dn < PMIN_X) ? PMIN_X : dn;
      up_cl = (up > PMAX_X) ? PMAX_X : up;

      tgt = {1'b0, bus.targetPeriodI};
      if (tgt < PMIN_X)      tgt = PMIN_X;
      else if (tgt > PMAX_X) tgt = PMAX_X;
      // Clamp each step at the target so tracking lands on it exactly.
      if (p_x > tgt) trk = (dn < tgt) ? tgt : dn;
      else           trk = (up > tgt) ? tgt : up;

      if (bus.forceStopI)       req = S_BRAKE;
      else if (bus.targetModeI) req = (p_x == tgt) ? S_HOLD : S_TRACK;
      else if (bus.speedIncI)   req = S_INC;
      else if (bus.speedDecI)   req = S_DEC;
      else                      req = S_HOLD;

      case (req)
         S_INC:   nxt_p = dn_cl;
         S_DEC:   nxt_p = up_cl;
         default: nxt_p = trk;
      endcase
   end

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         st        <= S_IDLE;
         period    <= PMAX_W;
         rnd       <= RND_RLD;
         step_done <= 1'b0;
      end else if (!bus.workingI) begin
         st        <= S_IDLE;
         period    <= PMAX_W;
         rnd       <= RND_RLD;
         step_done <= 1'b0;
      end else begin
         step_done <= 1'b0;
         if (bus.nextRoundI) begin
            st <= req;
            if (req == S_BRAKE) begin
               rnd       <= RND_RLD;
               period    <= up_cl[PERIOD_W-1:0];
               step_done <= (up_cl != p_x);
            // Leaving IDLE counts the pulse in the new state rather than reloading.
            end else if (req == S_HOLD || (req != st && st != S_IDLE)) begin
               rnd <= RND_RLD;
            end else if (rnd != '0) begin
               rnd <= rnd - RW'(1);
            end else begin
               rnd       <= RND_RLD;
               period    <= nxt_p[PERIOD_W-1:0];
               step_done <= (nxt_p != p_x);
               if (req == S_TRACK && nxt_p == tgt) st <= S_HOLD;
            end
         end
      end
   end

   m3_tick_div #(.TICK_MAX(TICK_MAX)) u_tick (
      .clkI  (clkI),
      .nRstI (nRstI),
      .en    (bus.workingI),
      .tick  (bus.tickO)
   );

   assign bus.periodO   = period;
   assign bus.atMinO    = (period == PMIN_W);
   assign bus.atMaxO    = (period == PMAX_W);
   assign bus.stateO    = st;
   assign bus.stepDoneO = step_done;
endmodule

// File: tb/tb_m3_speed_ramp_ctrl.sv
// Directed bench for the ramp controller with hand-derived period sequences.
module tb_m3_speed_ramp_ctrl;
   import m3_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   m3_speed_ramp_ctrl_if #(.PERIOD_W(32)) bus ();

   m3_speed_ramp_ctrl #(
      .PERIOD_W   (32),
      .PERIOD_MAX (300),
      .PERIOD_MIN (40),
      .STEP_SHIFT (4),
      .ROUND_MAX  (3),
      .TICK_MAX   (9)
   ) dut (
      .clkI  (clk),
      .nRstI (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves us just after the pulse edge, where stepDoneO for that pulse is visible.
   task automatic pulse();
      idle(1);
      bus.nextRoundI = 1'b1;
      @(posedge clk);
      #1;
      bus.nextRoundI = 1'b0;
   endtask

   task automatic pulses(input int n);
      repeat (n) pulse();
   endtask

   task automatic restart();
      bus.workingI = 1'b0;
      idle(1);
      bus.workingI = 1'b1;
   endtask

   int steps, p, s, first, ticks, seen;
   int trk_exp[12] = '{300, 300, 300, 282, 282, 282, 282, 265, 265, 265, 265, 250};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.workingI = 1'b0;  bus.nextRoundI = 1'b0;  bus.forceStopI = 1'b0;
      bus.speedIncI = 1'b0; bus.speedDecI = 1'b0;   bus.targetModeI = 1'b0;
      bus.targetPeriodI = 32'd0;
      idle(3);
      chk("rst_period", bus.periodO, 300);
      chk("rst_atmax", bus.atMaxO, 1);
      chk("rst_atmin", bus.atMinO, 0);
      chk("rst_state", bus.stateO, S_IDLE);
      chk("rst_stepdone", bus.stepDoneO, 0);
      chk("rst_tick", bus.tickO, 0);
      rst_n = 1'b1;
      bus.workingI = 1'b1;

      // INC from reset: step lands on the 4th pulse
      bus.speedIncI = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         pulse();
         if (bus.stepDoneO) seen++;
      end
      chk("inc_pre_period", bus.periodO, 300);
      chk("inc_pre_stepdone", seen, 0);
      pulse();
      chk("inc_4th_period", bus.periodO, 282);
      chk("inc_4th_stepdone", bus.stepDoneO, 1);
      chk("inc_state", bus.stateO, S_INC);
      idle(1);
      chk("stepdone_one_cycle", bus.stepDoneO, 0);

      // INC to the clamp: 34 more steps down to exactly 40
      steps = 0;
      for (int i = 0; i < 400 && bus.atMinO !== 1'b1; i++) begin
         pulse();
         if (bus.stepDoneO) steps++;
      end
      chk("clamp_period", bus.periodO, 40);
      chk("clamp_atmin", bus.atMinO, 1);
      chk("clamp_steps", steps, 34);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         pulse();
         if (bus.stepDoneO) seen++;
      end
      chk("clamp_hold_period", bus.periodO, 40);
      chk("clamp_no_stepdone", seen, 0);

      // BRAKE from 40: steps immediately, every pulse, up to 300
      bus.speedIncI = 1'b0;
      bus.forceStopI = 1'b1;
      pulse();
      chk("brake_first", bus.periodO, 42);
      chk("brake_state", bus.stateO, S_BRAKE);
      chk("brake_stepdone", bus.stepDoneO, 1);
      p = 42;
      for (int i = 0; i < 200 && bus.atMaxO !== 1'b1; i++) begin
         s = p >> 4;
         if (s < 1) s = 1;
         p = (p + s > 300) ? 300 : p + s;
         pulse();
         chk("brake_seq", bus.periodO, p);
      end
      chk("brake_atmax", bus.atMaxO, 1);
      pulse();
      chk("brake_sat_period", bus.periodO, 300);
      chk("brake_sat_stepdone", bus.stepDoneO, 0);
      chk("brake_stay", bus.stateO, S_BRAKE);

      // INC twice after a step, then DEC: first DEC pulse only reloads
      bus.forceStopI = 1'b0;
      restart();
      bus.speedIncI = 1'b1;
      pulses(4);
      chk("re_inc_period", bus.periodO, 282);
      pulses(2);
      bus.speedIncI = 1'b0;
      bus.speedDecI = 1'b1;
      pulse();
      chk("dec_enter_state", bus.stateO, S_DEC);
      chk("dec_enter_period", bus.periodO, 282);
      pulses(3);
      chk("dec_4th_period", bus.periodO, 282);
      pulse();
      chk("dec_5th_period", bus.periodO, 299);
      chk("dec_5th_stepdone", bus.stepDoneO, 1);
      pulses(4);
      chk("dec_clamp_max", bus.periodO, 300);
      bus.speedIncI = 1'b1;
      pulse();
      chk("inc_dec_both", bus.stateO, S_INC);
      bus.speedIncI = 1'b0;
      bus.speedDecI = 1'b0;
      pulse();
      chk("no_req_hold", bus.stateO, S_HOLD);

      // TRACK to 250: 282, 265, 250 then HOLD
      restart();
      bus.targetModeI = 1'b1;
      bus.targetPeriodI = 32'd250;
      for (int i = 0; i < 12; i++) begin
         pulse();
         chk("track_seq", bus.periodO, trk_exp[i]);
      end
      chk("track_hold", bus.stateO, S_HOLD);
      pulses(2);
      chk("track_stay_period", bus.periodO, 250);

      // Target below range clamps to 40
      bus.targetPeriodI = 32'd10;
      pulses(5);
      chk("track_low_first", bus.periodO, 235);
      chk("track_low_state", bus.stateO, S_TRACK);
      for (int i = 0; i < 400 && bus.stateO !== S_HOLD; i++) pulse();
      chk("track_low_land", bus.periodO, 40);
      chk("track_low_atmin", bus.atMinO, 1);
      chk("track_low_hold", bus.stateO, S_HOLD);

      // Drop workingI mid-ramp
      bus.targetModeI = 1'b0;
      bus.speedDecI = 1'b1;
      pulses(5);
      chk("midramp_period", bus.periodO, 42);
      bus.workingI = 1'b0;
      idle(1);
      chk("drop_period", bus.periodO, 300);
      chk("drop_state", bus.stateO, S_IDLE);
      chk("drop_atmax", bus.atMaxO, 1);
      bus.speedDecI = 1'b0;

      // Tick only while workingI high, every 10 clocks
      ticks = 0;
      for (int k = 0; k < 25; k++) begin
         idle(1);
         if (bus.tickO) ticks++;
      end
      chk("tick_off", ticks, 0);
      bus.workingI = 1'b1;
      ticks = 0;
      first = -1;
      for (int k = 1; k <= 30; k++) begin
         idle(1);
         if (bus.tickO) begin
            if (first < 0) first = k;
            ticks++;
         end
      end
      chk("tick_first", first, 9);
      chk("tick_count", ticks, 3);
      bus.workingI = 1'b0;
      ticks = 0;
      for (int k = 0; k < 25; k++) begin
         idle(1);
         if (bus.tickO) ticks++;
      end
      chk("tick_off_again", ticks, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
